// File: rtl/aes_mask_ctrl.sv
// Job sequencer for a single aes_mask core: accepts one job, issues init / N x next / finalize,
// captures the core result and holds it on a valid/ready output until taken.
module aes_mask_ctrl #(
    parameter int ROUNDS_128 = 10,
    parameter int ROUNDS_256 = 14
) (
    input  logic         clk,
    input  logic         reset,
    // Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_key,
    input  logic         in_keylen,
    input  logic [127:0] in_block,
    input  logic         abort,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_result,
    output logic         busy,
    output logic         mask_init,
    output logic         mask_next,
    output logic         mask_finalize,
    output logic [127:0] mask_key,
    output logic         mask_keylen,
    output logic [127:0] mask_block,
    input  logic [127:0] mask_result,
    output logic [2:0]   dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_CAPT  = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    localparam logic [3:0] N128 = 4'(ROUNDS_128);
    localparam logic [3:0] N256 = 4'(ROUNDS_256);

    state_e       state_q;
    logic [3:0]   round_cnt_q;
    logic [3:0]   round_cnt_d;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         busy_q;
    logic         init_q;
    logic         next_q;
    logic         fin_q;
    logic [127:0] out_result_q;
    logic [127:0] key_q;
    logic         keylen_q;
    logic [127:0] block_q;

    // Saturating decrement keeps the counter from wrapping if ROUND is ever entered at zero.
    assign round_cnt_d = (round_cnt_q != 4'd0) ? round_cnt_q - 4'd1 : 4'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            round_cnt_q  <= 4'd0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            init_q       <= 1'b0;
            next_q       <= 1'b0;
            fin_q        <= 1'b0;
            out_result_q <= 128'd0;
            key_q        <= 128'd0;
            keylen_q     <= 1'b0;
            block_q      <= 128'd0;
        end else begin
            init_q <= 1'b0;
            next_q <= 1'b0;
            fin_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        key_q       <= in_key;
                        keylen_q    <= in_keylen;
                        block_q     <= in_block;
                        round_cnt_q <= in_keylen ? N256 : N128;
                        state_q     <= S_INIT;
                        init_q      <= 1'b1;
                        in_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                S_INIT, S_ROUND, S_FINAL, S_CAPT: begin
                    if (abort) begin
                        state_q     <= S_IDLE;
                        round_cnt_q <= 4'd0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end else if (state_q == S_INIT) begin
                        state_q <= S_ROUND;
                        next_q  <= 1'b1;
                    end else if (state_q == S_ROUND) begin
                        round_cnt_q <= round_cnt_d;
                        if (round_cnt_q <= 4'd1) begin
                            state_q <= S_FINAL;
                            fin_q   <= 1'b1;
                        end else begin
                            next_q <= 1'b1;
                        end
                    end else if (state_q == S_FINAL) begin
                        state_q <= S_CAPT;
                    end else begin
                        out_result_q <= mask_result;
                        out_valid_q  <= 1'b1;
                        state_q      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_result    = out_result_q;
    assign busy          = busy_q;
    assign mask_init     = init_q;
    assign mask_next     = next_q;
    assign mask_finalize = fin_q;
    assign mask_key      = key_q;
    assign mask_keylen   = keylen_q;
    assign mask_block    = block_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_aes_mask_ctrl.sv
// Directed bench for aes_mask_ctrl with a small behavioural stand-in for the aes_mask core.
module tb_aes_mask_ctrl;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_key;
    logic         in_keylen;
    logic [127:0] in_block;
    logic         abort;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_result;
    logic         busy;
    logic         mask_init;
    logic         mask_next;
    logic         mask_finalize;
    logic [127:0] mask_key;
    logic         mask_keylen;
    logic [127:0] mask_block;
    logic [127:0] mask_result;
    logic [2:0]   dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [127:0] exp_q[$];
    logic [127:0] last_exp = 128'd0;

    int init_cnt = 0, next_cnt = 0, fin_cnt = 0, ov_cnt = 0, acc_cnt = 0;
    int onehot_viol = 0, stab_viol = 0;
    logic [127:0] acc_key = 128'd0, acc_block = 128'd0;
    logic         acc_keylen = 1'b0;
    logic [127:0] core_q = 128'd0;

    aes_mask_ctrl #(.ROUNDS_128(10), .ROUNDS_256(14)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key), .in_keylen(in_keylen),
        .in_block(in_block), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .busy(busy),
        .mask_init(mask_init), .mask_next(mask_next), .mask_finalize(mask_finalize),
        .mask_key(mask_key), .mask_keylen(mask_keylen), .mask_block(mask_block),
        .mask_result(mask_result), .dbg_state(dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core stand-in: init loads key^block, next rotates and mixes in the key, finalize inverts.
    always @(posedge clk) begin
        if (mask_init)          core_q <= mask_key ^ mask_block;
        else if (mask_next)     core_q <= {core_q[126:0], core_q[127]} ^ mask_key;
        else if (mask_finalize) core_q <= ~core_q;
    end
    assign mask_result = core_q;

    function automatic logic [127:0] ref_result(input logic [127:0] k, input logic [127:0] b, input int n);
        logic [127:0] s;
        s = k ^ b;
        for (int i = 0; i < n; i++) s = {s[126:0], s[127]} ^ k;
        return ~s;
    endfunction

    // Monitors sample mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (int'(mask_init) + int'(mask_next) + int'(mask_finalize) > 1) onehot_viol++;
        if (mask_init)     init_cnt++;
        if (mask_next)     next_cnt++;
        if (mask_finalize) fin_cnt++;
        if (out_valid)     ov_cnt++;
        if (busy && (mask_key !== acc_key || mask_block !== acc_block || mask_keylen !== acc_keylen))
            stab_viol++;
        if (!reset && in_valid && in_ready) begin
            acc_cnt++;
            acc_key    <= in_key;
            acc_block  <= in_block;
            acc_keylen <= in_keylen;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            cyc();
            lat++;
        end
        if (!out_valid) chk("out_valid_timeout", 128'd0, 128'd1);
    endtask

    task automatic check_result(input string tag);
        logic [127:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_no_expect"}, 128'd0, 128'd1);
        end else begin
            e = exp_q.pop_front();
            last_exp = e;
            chk(tag, out_result, e);
        end
    endtask

    task automatic drive_job(input logic [127:0] k, input logic [127:0] b, input logic kl);
        in_key    = k;
        in_block  = b;
        in_keylen = kl;
        in_valid  = 1'b1;
        cyc();
        in_valid  = 1'b0;
        in_key    = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_block  = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_keylen = ~kl;
    endtask

    task automatic run_job(input string tag, input logic [127:0] k, input logic [127:0] b,
                           input logic kl, input int hold);
        int n, lat, i0, n0, f0;
        n  = kl ? 14 : 10;
        i0 = init_cnt; n0 = next_cnt; f0 = fin_cnt;
        exp_q.push_back(ref_result(k, b, n));
        out_ready = (hold == 0);
        chk({tag, "_ready_idle"}, in_ready, 1);
        drive_job(k, b, kl);
        chk({tag, "_busy"}, busy, 1);
        wait_out(lat);
        chk({tag, "_latency"}, lat, n + 3);
        check_result({tag, "_result"});
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0];
            cyc();
            chk({tag, "_hold_valid"}, out_valid, 1);
            chk({tag, "_hold_result"}, out_result, last_exp);
            chk({tag, "_hold_ready"}, in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc();
        chk({tag, "_valid_drop"}, out_valid, 0);
        chk({tag, "_idle_state"}, dbg_state, 0);
        chk({tag, "_n_init"}, init_cnt - i0, 1);
        chk({tag, "_n_next"}, next_cnt - n0, n);
        chk({tag, "_n_fin"}, fin_cnt - f0, 1);
    endtask

    initial begin
        int i0, n0, f0, ov0, a0, lat;
        reset = 1'b1; in_valid = 1'b0; in_key = '0; in_keylen = 1'b0; in_block = '0;
        abort = 1'b0; out_ready = 1'b0;
        cyc();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_strobes", {mask_init, mask_next, mask_finalize}, 0);
        chk("rst_job_regs", mask_key | mask_block | 128'(mask_keylen), 0);
        chk("rst_state", dbg_state, 0);
        reset = 1'b0;
        cyc();

        run_job("job128", 128'h000102030405060708090a0b0c0d0e0f,
                128'h00112233445566778899aabbccddeeff, 1'b0, 0);
        run_job("job256", 128'hffeeddccbbaa99887766554433221100,
                128'h0123456789abcdeffedcba9876543210, 1'b1, 5);

        // Abort on the 4th ROUND cycle
        i0 = init_cnt; n0 = next_cnt; f0 = fin_cnt; ov0 = ov_cnt;
        out_ready = 1'b1;
        drive_job(128'hdeadbeefdeadbeefdeadbeefdeadbeef, 128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a, 1'b0);
        repeat (4) cyc();
        chk("abort_in_round", dbg_state, 2);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_idle", dbg_state, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", in_ready, 1);
        repeat (10) cyc();
        chk("abort_n_init", init_cnt - i0, 1);
        chk("abort_n_next", next_cnt - n0, 4);
        chk("abort_n_fin", fin_cnt - f0, 0);
        chk("abort_no_valid", ov_cnt - ov0, 0);
        chk("abort_result_kept", out_result, last_exp);
        run_job("after_abort", 128'h13579bdf02468ace13579bdf02468ace,
                128'hcafef00dcafef00dcafef00dcafef00d, 1'b0, 0);

        // Asynchronous reset between edges mid-ROUND
        drive_job(128'h11111111222222223333333344444444, 128'h55555555666666667777777788888888, 1'b1);
        repeat (4) cyc();
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_next", mask_next, 0);
        chk("arst_key", mask_key, 0);
        chk("arst_result", out_result, 0);
        chk("arst_state", dbg_state, 0);
        cyc();
        reset = 1'b0;
        cyc();
        chk("arst_release_ready", in_ready, 1);
        chk("arst_release_busy", busy, 0);

        // Two jobs back-to-back with in_valid held high
        i0 = init_cnt; n0 = next_cnt; f0 = fin_cnt; a0 = acc_cnt;
        exp_q.push_back(ref_result(128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5, 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f, 10));
        exp_q.push_back(ref_result(128'h0123012301230123abcdabcdabcdabcd, 128'h99998888777766665555444433332222, 14));
        out_ready = 1'b1;
        in_key = 128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5;
        in_block = 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f;
        in_keylen = 1'b0;
        in_valid = 1'b1;
        cyc();
        chk("b2b_first_busy", busy, 1);
        in_key = 128'h0123012301230123abcdabcdabcdabcd;
        in_block = 128'h99998888777766665555444433332222;
        in_keylen = 1'b1;
        wait_out(lat);
        check_result("b2b_result_a");
        cyc();
        chk("b2b_idle_gap", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        chk("b2b_second_busy", busy, 1);
        wait_out(lat);
        check_result("b2b_result_b");
        cyc();
        chk("b2b_end_idle", dbg_state, 0);
        chk("b2b_accepts", acc_cnt - a0, 2);
        chk("b2b_n_init", init_cnt - i0, 2);
        chk("b2b_n_next", next_cnt - n0, 24);
        chk("b2b_n_fin", fin_cnt - f0, 2);

        chk("onehot_strobes", onehot_viol, 0);
        chk("job_regs_stable", stab_viol, 0);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
